// File: rtl/swap_scheduler.sv
// Arbitrated register-exchange controller: two requesters swap bank entries via temporaries, host port loads/reads the bank.
// Optional macro SWAP_RR_EN selects round-robin arbitration; default build is fixed priority (req0 wins).
module swap_scheduler #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IDXW-1:0]  req0_idx_a,
  input  logic [IDXW-1:0]  req0_idx_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IDXW-1:0]  req1_idx_a,
  input  logic [IDXW-1:0]  req1_idx_b,
  input  logic             wr_en,
  output logic             wr_ready,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  localparam int DEPTH = 1 << IDXW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] bank [DEPTH];
  logic [WIDTH-1:0] tmp_a, tmp_b;
  logic [IDXW-1:0]  idx_a, idx_b;
  logic             owner;
  logic             idle;
  logic             grant0, grant1;

  assign idle = (state == S_IDLE);

`ifdef SWAP_RR_EN
  logic last_grant;

  // Contested cycle goes to whichever requester was not granted last.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (idle && !wr_en && (grant0 || grant1)) begin
      last_grant <= grant1;
    end
  end
`else
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`endif

  // Host write owns the idle cycle, so swaps see no grant while wr_en is up.
  assign req0_ready = idle & ~wr_en & grant0;
  assign req1_ready = idle & ~wr_en & grant1;
  assign wr_ready   = idle;
  assign busy       = ~idle;
  assign done       = (state == S_DONE);
  assign done_id    = done & owner;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tmp_a   <= '0;
      tmp_b   <= '0;
      idx_a   <= '0;
      idx_b   <= '0;
      owner   <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      rd_data <= bank[rd_idx];
      case (state)
        S_IDLE: begin
          if (wr_en) begin
            bank[wr_idx] <= wr_data;
          end else if (grant0 || grant1) begin
            idx_a <= grant1 ? req1_idx_a : req0_idx_a;
            idx_b <= grant1 ? req1_idx_b : req0_idx_b;
            owner <= grant1;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          tmp_a <= bank[idx_a];
          tmp_b <= bank[idx_b];
          state <= S_COMMIT;
        end
        S_COMMIT: begin
          // Equal indices write the same value twice, leaving the entry intact.
          bank[idx_a] <= tmp_b;
          bank[idx_b] <= tmp_a;
          state       <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swap_scheduler.sv
// Randomized bench for swap_scheduler against a transaction-level bank/arbiter model.
module tb_swap_scheduler;
  localparam int WIDTH = 8;
  localparam int IDXW  = 3;
  localparam int DEPTH = 8;
`ifdef SWAP_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [IDXW-1:0]  req0_idx_a, req0_idx_b;
  logic             req1_valid, req1_ready;
  logic [IDXW-1:0]  req1_idx_a, req1_idx_b;
  logic             wr_en, wr_ready;
  logic [IDXW-1:0]  wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [IDXW-1:0]  rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             busy, done, done_id;

  int vectors    = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] m_bank [DEPTH];
  bit               m_last;

  swap_scheduler #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_idx_a(req0_idx_a), .req0_idx_b(req0_idx_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_idx_a(req1_idx_a), .req1_idx_b(req1_idx_b),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
    m_last = 1'b1;
  endtask

  task automatic release_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic host_write(input logic [IDXW-1:0] idx, input logic [WIDTH-1:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    #1;
    check("wr_ready_idle", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_en = 1'b0;
    m_bank[idx] = data;
    #1;
  endtask

  task automatic check_bank();
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = IDXW'(i);
      @(negedge clk);
      #1;
      check($sformatf("bank[%0d]", i), 32'(rd_data), 32'(m_bank[i]));
    end
  endtask

  // Called in IDLE just after a falling edge; leaves the valids as given.
  task automatic do_swap(input bit v0, input bit v1,
                         input logic [IDXW-1:0] a0, input logic [IDXW-1:0] b0,
                         input logic [IDXW-1:0] a1, input logic [IDXW-1:0] b1,
                         input bit hw, input logic [IDXW-1:0] hw_idx,
                         input logic [WIDTH-1:0] hw_data);
    bit               own;
    logic [IDXW-1:0]  ia, ib;
    logic [WIDTH-1:0] old_a, t;
    int               lat;
    own = (v0 && v1) ? (RR ? ~m_last : 1'b0) : ~v0;
    ia  = own ? a1 : a0;
    ib  = own ? b1 : b0;
    req0_valid = v0; req0_idx_a = a0; req0_idx_b = b0;
    req1_valid = v1; req1_idx_a = a1; req1_idx_b = b1;
    rd_idx = ia;
    #1;
    check("busy_before_accept", 32'(busy), 32'd0);
    check("req0_ready_grant", 32'(req0_ready), 32'(own == 1'b0));
    check("req1_ready_grant", 32'(req1_ready), 32'(own == 1'b1));
    old_a = m_bank[ia];
    lat = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1 && hw) begin
        wr_en = 1'b1; wr_idx = hw_idx; wr_data = hw_data;
      end
      #1;
      check("busy_in_swap", 32'(busy), 32'd1);
      check("wr_ready_in_swap", 32'(wr_ready), 32'd0);
      check("ready_in_swap", 32'({req0_ready, req1_ready}), 32'd0);
      if (done === 1'b1) lat = n;
    end
    check("done_latency", 32'(lat), 32'd3);
    check("done_id", 32'(done_id), 32'(own));
    check("rd_pre_commit", 32'(rd_data), 32'(old_a));
    t = m_bank[ia];
    m_bank[ia] = m_bank[ib];
    m_bank[ib] = t;
    m_last = own;
    @(negedge clk);
    #1;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_single_pulse", 32'(done), 32'd0);
    check("wr_ready_back", 32'(wr_ready), 32'd1);
    check("rd_post_commit", 32'(rd_data), 32'(m_bank[ia]));
    if (hw) begin
      check("host_priority", 32'({req0_ready, req1_ready}), 32'd0);
      @(negedge clk);
      wr_en = 1'b0;
      m_bank[hw_idx] = hw_data;
      #1;
    end
  endtask

  task automatic reset_mid_swap();
    req0_valid = 1'b1; req0_idx_a = 3'd2; req0_idx_b = 3'd3; rd_idx = 3'd2;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1;
    check("busy_commit", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("rst_no_done", 32'(done), 32'd0);
  endtask

  initial begin
    bit               v0, v1, hw;
    logic [IDXW-1:0]  a0, b0, a1, b1, hi;
    logic [WIDTH-1:0] hd;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_idx_a = '0; req0_idx_b = '0; req1_idx_a = '0; req1_idx_b = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_done_id", 32'(done_id), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    check("reset_req_ready", 32'({req0_ready, req1_ready}), 32'd0);

    // Basic swap, then same-index swap from requester 1
    host_write(3'd0, 8'h11);
    host_write(3'd1, 8'h22);
    do_swap(1'b1, 1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0, 8'h00);
    release_reqs();
    check_bank();
    host_write(3'd5, 8'hA5);
    do_swap(1'b0, 1'b1, 3'd0, 3'd0, 3'd5, 3'd5, 1'b0, 3'd0, 8'h00);
    release_reqs();
    check_bank();

    // Continuous contention straight after reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < DEPTH; i++) host_write(IDXW'(i), WIDTH'($urandom));
    for (int i = 0; i < 4; i++)
      do_swap(1'b1, 1'b1, 3'd0, 3'd7, 3'd2, 3'd4, 1'b0, 3'd0, 8'h00);
    release_reqs();
    check_bank();

    // Host write arriving during FETCH lands after COMMIT on the swapped entry
    do_swap(1'b1, 1'b0, 3'd2, 3'd6, 3'd0, 3'd0, 1'b1, 3'd2, 8'h5C);
    release_reqs();
    check_bank();

    // Reset during COMMIT, then a normal swap
    host_write(3'd2, 8'hC3);
    reset_mid_swap();
    check_bank();
    host_write(3'd3, 8'h77);
    do_swap(1'b0, 1'b1, 3'd0, 3'd0, 3'd3, 3'd4, 1'b0, 3'd0, 8'h00);
    release_reqs();
    check_bank();

    // Randomized mix of writes, single and contested swaps
    for (int it = 0; it < 40; it++) begin
      a0 = IDXW'($urandom); b0 = IDXW'($urandom);
      a1 = IDXW'($urandom); b1 = IDXW'($urandom);
      hi = IDXW'($urandom); hd = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: host_write(hi, hd);
        1: begin
          v0 = 1'($urandom); v1 = ~v0; hw = 1'b0;
          do_swap(v0, v1, a0, b0, a1, b1, hw, hi, hd);
          release_reqs();
        end
        2: begin
          do_swap(1'b1, 1'b1, a0, b0, a1, b1, 1'b0, hi, hd);
          release_reqs();
        end
        default: begin
          v0 = 1'($urandom); v1 = 1'($urandom);
          if (!v0 && !v1) v0 = 1'b1;
          do_swap(v0, v1, a0, b0, a1, b1, 1'b1, hi, hd);
          release_reqs();
        end
      endcase
      if (it % 10 == 9) check_bank();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
